// File: rtl/fp_expand.sv
// fp_expand: 8-bit float code (S/E/F) to 12-bit two's-complement value.
// Iterative one-bit-per-cycle shift behind valid/ready handshakes.
module fp_expand (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        S,
    input  logic [2:0]  E,
    input  logic [3:0]  F,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] D
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FORM,
        DONE
    } state_t;

    state_t      state, state_nx;
    logic [11:0] mag, mag_nx;
    logic [2:0]  cnt, cnt_nx;
    logic        sgn, sgn_nx;
    logic        in_ready_nx;
    logic        out_valid_nx;
    logic [11:0] d_nx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mag       <= '0;
            cnt       <= '0;
            sgn       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            D         <= '0;
        end else begin
            state     <= state_nx;
            mag       <= mag_nx;
            cnt       <= cnt_nx;
            sgn       <= sgn_nx;
            in_ready  <= in_ready_nx;
            out_valid <= out_valid_nx;
            D         <= d_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        mag_nx       = mag;
        cnt_nx       = cnt;
        sgn_nx       = sgn;
        in_ready_nx  = in_ready;
        out_valid_nx = out_valid;
        d_nx         = D;
        unique case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    mag_nx      = {8'b0, F};
                    cnt_nx      = E;
                    sgn_nx      = S;
                    in_ready_nx = 1'b0;
                    state_nx    = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt != 3'd0) begin
                    mag_nx = mag << 1;
                    cnt_nx = cnt - 3'd1;
                end else begin
                    state_nx = FORM;
                end
            end
            FORM: begin
                // mag <= 1920 fits in 11 bits, so negation never overflows
                d_nx         = sgn ? (~mag + 12'd1) : mag;
                out_valid_nx = 1'b1;
                state_nx     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_nx = 1'b0;
                    in_ready_nx  = 1'b1;
                    state_nx     = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fp_expand.sv
// Directed-vector bench for fp_expand.
// Checks values, latencies, backpressure and reset behaviour.
module tb_fp_expand;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        S;
    logic [2:0]  E;
    logic [3:0]  F;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] D;

    int checks = 0;
    int errors = 0;

    fp_expand dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (S),
        .E         (E),
        .F         (F),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called #1 after the accept edge; waits for out_valid within a bound.
    task automatic wait_done(input string tag, input int lat,
                             input logic [11:0] exp_d);
        int   n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            seen = out_valid;
        end
        check({tag, "_lat"}, 16'(n), 16'(lat));
        check({tag, "_d"}, 16'(D), 16'(exp_d));
        check({tag, "_busy"}, 16'(in_ready), 16'd0);
    endtask

    // Called #1 after out_valid rose with out_ready high.
    task automatic handoff(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_ov_drop"}, 16'(out_valid), 16'd0);
        check({tag, "_rdy_back"}, 16'(in_ready), 16'd1);
    endtask

    task automatic decode(input string tag, input logic s,
                          input logic [2:0] e, input logic [3:0] f,
                          input logic [11:0] exp_d);
        S        = s;
        E        = e;
        F        = f;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        S        = ~s;
        E        = ~e;
        F        = ~f;
        check({tag, "_acc"}, 16'(in_ready), 16'd0);
        wait_done(tag, int'(e) + 2, exp_d);
        handoff(tag);
    endtask

    initial begin
        logic seen;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        S         = 1'($urandom);
        E         = 3'($urandom);
        F         = 4'($urandom);
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 16'(in_ready), 16'd1);
        check("rst_out_valid", 16'(out_valid), 16'd0);
        check("rst_d", 16'(D), 16'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_idle", 16'(in_ready), 16'd1);

        out_ready = 1'b1;
        decode("pos", 1'b0, 3'd3, 4'd13, 12'h068);
        decode("negmax", 1'b1, 3'd7, 4'd15, 12'h880);
        decode("one", 1'b0, 3'd0, 4'd1, 12'h001);
        decode("negzero", 1'b1, 3'd5, 4'd0, 12'h000);
        decode("unnorm", 1'b0, 3'd2, 4'd3, 12'h00C);

        // backpressure with a competing code waiting upstream
        out_ready = 1'b0;
        S         = 1'b1;
        E         = 3'd1;
        F         = 4'd9;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done("bp", 3, 12'hFEE);
        S        = 1'b0;
        E        = 3'd2;
        F        = 4'd5;
        in_valid = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            check("bp_hold_d", 16'(D), 16'h0FEE);
            check("bp_hold_ov", 16'(out_valid), 16'd1);
            check("bp_hold_rdy", 16'(in_ready), 16'd0);
        end
        out_ready = 1'b1;
        handoff("bp");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_pending_acc", 16'(in_ready), 16'd0);
        wait_done("bp_pending", 4, 12'h014);
        handoff("bp_pending");

        // reset in the middle of a decode discards it
        S        = 1'b0;
        E        = 3'd6;
        F        = 4'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid_rst_rdy", 16'(in_ready), 16'd1);
        check("mid_rst_ov", 16'(out_valid), 16'd0);
        check("mid_rst_d", 16'(D), 16'd0);
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("mid_rst_no_result", 16'(seen), 16'd0);
        decode("after_rst", 1'b0, 3'd2, 4'd5, 12'h014);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
